// File: rtl/vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter
//
// Shares the single VGA plot port between several sprite drawers. One
// requester is granted at a time, chosen round-robin. A grant is held until
// the requester pulses done, drops its request, or the watchdog expires.
// The granted requester's pixel stream is forwarded to the VGA adapter
// through one register stage.
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no grant; pick next requester from rr_ptr upward (wraps)
//   S_ACTIVE  | requester g_idx owns the plot port; watchdog counting
//   S_RELEASE | one-cycle gap; grant/plot low, rr_ptr advanced past g_idx
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   req          in   [N_REQ]    level-held draw request per requester
//   done         in   [N_REQ]    end-of-sprite pulse per requester
//   x_in         in   [9*N_REQ]  packed pixel x, 9 bits per requester
//   y_in         in   [8*N_REQ]  packed pixel y, 8 bits per requester
//   colour_in    in   [3*N_REQ]  packed pixel colour, 3 bits per requester
//   plot_in      in   [N_REQ]    pixel-valid per requester
//   grant        out  [N_REQ]    one-hot grant, zero when nobody granted
//   x, y, colour out  9/8/3      registered pixel to the VGA adapter
//   plot         out  1          registered VGA write enable
//   busy         out  1          high whenever the state is not S_IDLE
//   timeout_err  out  1          one-cycle pulse on a watchdog release
// ---------------------------------------------------------------------------
module vga_draw_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [9*N_REQ-1:0]   x_in,
    input  logic [8*N_REQ-1:0]   y_in,
    input  logic [3*N_REQ-1:0]   colour_in,
    input  logic [N_REQ-1:0]     plot_in,
    output logic [N_REQ-1:0]     grant,
    output logic [8:0]           x,
    output logic [7:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   g_idx;
    logic [WD_W-1:0]    wdog;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [8:0]         sel_x;
    logic [7:0]         sel_y;
    logic [2:0]         sel_colour;
    logic               sel_plot;
    logic               sel_done;
    logic               sel_req;
    logic               wd_hit;
    logic               exit_active;

    // Round-robin pick: first set request at or after rr_ptr, with wrap.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand     = (int'(rr_ptr) + i) % N_REQ;
            cand_idx = PTR_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Slice mux for the granted requester (constant part-select bases).
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_done   = 1'b0;
        sel_req    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g_idx == PTR_W'(i)) begin
                sel_x      = x_in[9*i +: 9];
                sel_y      = y_in[8*i +: 8];
                sel_colour = colour_in[3*i +: 3];
                sel_plot   = plot_in[i];
                sel_done   = done[i];
                sel_req    = req[i];
            end
        end
    end

    // The first ACTIVE cycle sees wdog = 0, so the hit lands on the
    // TIMEOUT-th cycle of the grant and the counter never wraps.
    assign wd_hit      = (wdog == WD_W'(TIMEOUT - 1));
    assign exit_active = sel_done || !sel_req || wd_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            g_idx       <= '0;
            wdog        <= '0;
            grant       <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    plot <= 1'b0;
                    wdog <= '0;
                    if (pick_valid) begin
                        state <= S_ACTIVE;
                        g_idx <= pick_idx;
                        grant <= N_REQ'(1) << pick_idx;
                        busy  <= 1'b1;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end

                S_ACTIVE: begin
                    // Forwarded on the exit edge too, so a pixel coinciding
                    // with done is still written.
                    x      <= sel_x;
                    y      <= sel_y;
                    colour <= sel_colour;
                    plot   <= sel_plot;
                    if (exit_active) begin
                        state       <= S_RELEASE;
                        grant       <= '0;
                        wdog        <= '0;
                        // Only a pure watchdog expiry counts as forced.
                        timeout_err <= wd_hit && sel_req && !sel_done;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end

                S_RELEASE: begin
                    state  <= S_IDLE;
                    grant  <= '0;
                    plot   <= 1'b0;
                    busy   <= 1'b0;
                    wdog   <= '0;
                    rr_ptr <= (g_idx == PTR_W'(N_REQ - 1)) ? '0
                                                           : g_idx + PTR_W'(1);
                end

                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    wdog  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
module tb_vga_draw_arbiter;

    localparam int N  = 3;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, done, plot_in;
    logic [9*N-1:0]   x_in;
    logic [8*N-1:0]   y_in;
    logic [3*N-1:0]   colour_in;
    logic [N-1:0]     grant;
    logic [8:0]       x;
    logic [7:0]       y;
    logic [2:0]       colour;
    logic             plot, busy, timeout_err;

    vga_draw_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
        .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int ptr     = 0;   // model's round-robin starting point

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester in pattern p at or after index start, with wrap.
    function automatic int pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++)
            if (p[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic drive_rand();
        x_in      = 27'($urandom);
        y_in      = 24'($urandom);
        colour_in = 9'($urandom);
        plot_in   = 3'($urandom);
    endtask

    // One grant episode. mode: 0 = done ends it, 1 = request dropped,
    // 2 = watchdog. fixed: 0 = random data, 1 = winner draws (100,20,5)
    // every cycle, 2 = losers drive x=5/plot=1 and winner x is never 5.
    task automatic session(input logic [N-1:0] pat, input int mode,
                           input int len, input int fixed);
        int         w, n;
        logic [8:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        logic       ep;
        w   = pick(pat, ptr);
        ex  = '0; ey = '0; ec = '0; ep = 1'b0;
        req = pat;
        done = '0;
        drive_rand();
        @(posedge clk); #1;
        chk("grant_rise", 32'(grant), 32'(1 << w));
        chk("busy_rise",  32'(busy), 32'd1);
        chk("plot_idle",  32'(plot), 32'd0);
        n = (mode == 2) ? TO : len;
        for (int c = 0; c < n; c++) begin
            drive_rand();
            if (fixed == 1) begin
                x_in[9*w +: 9]      = 9'd100;
                y_in[8*w +: 8]      = 8'd20;
                colour_in[3*w +: 3] = 3'b101;
                plot_in[w]          = 1'b1;
            end else if (fixed == 2) begin
                for (int i = 0; i < N; i++) begin
                    if (i != w) begin
                        x_in[9*i +: 9] = 9'd5;
                        plot_in[i]     = 1'b1;
                    end
                end
                x_in[9*w +: 9] = 9'($urandom_range(6, 511));
            end
            done = 3'($urandom) & ~(3'b001 << w);
            if (c == n - 1) begin
                if (mode == 0)      done[w] = 1'b1;
                else if (mode == 1) req[w]  = 1'b0;
            end
            ex = x_in[9*w +: 9];
            ey = y_in[8*w +: 8];
            ec = colour_in[3*w +: 3];
            ep = plot_in[w];
            @(posedge clk); #1;
            chk("x_fwd",      32'(x), 32'(ex));
            chk("y_fwd",      32'(y), 32'(ey));
            chk("colour_fwd", 32'(colour), 32'(ec));
            chk("plot_fwd",   32'(plot), 32'(ep));
            chk("busy_active", 32'(busy), 32'd1);
            if (c == n - 1) begin
                chk("grant_fall",  32'(grant), 32'd0);
                chk("timeout_err", 32'(timeout_err), (mode == 2) ? 32'd1 : 32'd0);
            end else begin
                chk("grant_hold",  32'(grant), 32'(1 << w));
                chk("no_timeout",  32'(timeout_err), 32'd0);
            end
        end
        done    = '0;
        plot_in = '0;
        @(posedge clk); #1;
        chk("rel_grant", 32'(grant), 32'd0);
        chk("rel_plot",  32'(plot), 32'd0);
        chk("rel_busy",  32'(busy), 32'd0);
        chk("rel_terr",  32'(timeout_err), 32'd0);
        chk("rel_xhold", 32'(x), 32'(ex));
        ptr = (w + 1) % N;
    endtask

    initial begin
        reset = 1'b0;
        req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_plot",  32'(plot), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_x",     32'(x), 32'd0);
        chk("rst_terr",  32'(timeout_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        ptr = 0;

        // Contention, all held: 001, 010, 100, 001
        for (int k = 0; k < 4; k++) session(3'b111, 0, 5, 0);
        // Requester 1 granted while requester 0 drives x=5/plot
        session(3'b011, 0, 10, 2);
        // Single request, 40 fixed pixels
        session(3'b010, 0, 40, 1);
        // Watchdog on requester 2, then pointer must be 0
        session(3'b100, 2, 0, 0);
        session(3'b111, 0, 3, 0);
        // Withdrawal mid-grant
        session(3'b001, 1, 6, 0);

        // Randomized episodes
        for (int k = 0; k < 40; k++) begin
            int mode;
            mode = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
            session(3'($urandom_range(1, 7)), mode, int'($urandom_range(1, 20)), 0);
        end

        // Async reset in the middle of a grant with plot high
        session(3'b010, 0, 2, 0);          // leaves pointer at 2
        req = 3'b100; done = '0;
        drive_rand();
        plot_in = 3'b111;
        @(posedge clk); #1;
        chk("ar_grant", 32'(grant), 32'b100);
        @(posedge clk); #1;
        chk("ar_plot", 32'(plot), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_grant0", 32'(grant), 32'd0);
        chk("ar_plot0",  32'(plot), 32'd0);
        chk("ar_busy0",  32'(busy), 32'd0);
        chk("ar_x0",     32'(x), 32'd0);
        @(posedge clk); #1;
        chk("ar_plot_held", 32'(plot), 32'd0);
        req = '0; plot_in = '0;
        reset = 1'b1;
        ptr = 0;
        session(3'b101, 0, 3, 0);          // pointer reset -> requester 0
        session(3'b110, 0, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA plot port between sprite drawers (player, alien, bullet, ...), granting exactly one requester at a time.
- Round-robin fairness; a grant is held until the requester signals done, drops its request, or hits a watchdog timeout.
- The granted requester's x/y/colour/plot are forwarded to the VGA adapter through one register stage.
- Sits between the sprite controllers and the VGA adapter instance.

Parameters:
N_REQ, 3, number of requesters; index 0 is first priority after reset.
TIMEOUT, 64, maximum cycles a grant is held in ACTIVE before a forced release; must be at least 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester draw request, level-held
done  input  N_REQ  per-requester end-of-sprite pulse
x_in  input  9*N_REQ  packed pixel x; requester i uses bits [9i+8:9i]
y_in  input  8*N_REQ  packed pixel y; requester i uses bits [8i+7:8i]
colour_in  input  3*N_REQ  packed pixel colour; requester i uses bits [3i+2:3i]
plot_in  input  N_REQ  per-requester pixel-valid
grant  output  N_REQ  one-hot grant; all zero when no requester is granted
x  output  9  to VGA adapter
y  output  8  to VGA adapter
colour  output  3  to VGA adapter
plot  output  1  VGA write enable
busy  output  1  high whenever state is not IDLE
timeout_err  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset: reset is asynchronous and active-low. While it is low, all outputs are 0, state = IDLE, rr_ptr = 0, and the watchdog counter = 0. It takes effect immediately, including mid-grant. No pixel is written after reset asserts.
- State IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward with wrap-around. Index rr_ptr itself is eligible.
  - Register the pick as grant (one-hot) and go to ACTIVE.
  - Latency: grant is high on the cycle after req is first seen in IDLE.
  - If no req bit is set, stay in IDLE with grant = 0.
- State ACTIVE (granted index g):
  - Each cycle, x/y/colour/plot are registered from slice g. A plot_in[g] seen at edge k appears on plot at edge k+1.
  - plot_in, done and the data of non-granted requesters are ignored.
  - The watchdog counter increments each cycle spent in ACTIVE.
  - Leave ACTIVE on done[g] = 1, OR req[g] = 0, OR watchdog reaching TIMEOUT-1. On exit, go to RELEASE.
  - If done[g] and plot_in[g] are high in the same cycle, that final pixel is still forwarded.
  - Timeout exit only: timeout_err pulses high for exactly 1 cycle, coincident with entry to RELEASE.
- State RELEASE (1 cycle):
  - grant = 0 and plot = 0; x/y/colour hold their last values.
  - rr_ptr = (g+1) mod N_REQ; watchdog counter cleared.
  - Next state is IDLE.
- Back-to-back requests: the minimum gap from one grant falling to the next grant rising is 2 cycles (RELEASE, then IDLE).
- Simultaneous requests: resolved purely by rr_ptr order, so under continuous contention each requester waits at most N_REQ-1 grants.
- Invariants:
  - grant is one-hot or zero in every cycle.
  - plot can be high only while state = ACTIVE or on the cycle immediately after leaving ACTIVE (the registered final pixel). It is never high in IDLE.
- Widths: watchdog counter is ceil(log2(TIMEOUT)) bits and never wraps; rr_ptr is ceil(log2(N_REQ)) bits.

Test Plan:
- Reset then single request: req=3'b010, done pulsed after 40 plot cycles with x_in[1]=100, y_in[1]=20, colour=3'b101 -> grant=3'b010 one cycle after req; 40 plot pulses on the VGA port each delayed 1 cycle with matching x/y/colour; grant drops the cycle after done; busy low 2 cycles after done.
- Contention: req=3'b111 held, each requester pulses done 5 cycles after its grant -> grant order 001, 010, 100, 001; 2-cycle gap between consecutive grants.
- Ignore non-granted: req1 granted while req0 drives plot_in[0]=1 with x=5 -> x/plot reflect only requester 1; x never equals 5.
- Timeout: requester 2 granted and never pulses done, TIMEOUT=64 -> grant held 64 cycles; timeout_err high exactly 1 cycle; rr_ptr advances to 0.
- Request withdrawal: req[0] dropped mid-grant without done -> release on the next cycle; no timeout_err.
- Async reset mid-ACTIVE: reset low between clock edges while plot=1 -> grant, plot and busy go to 0 immediately without a clock edge; after release, req=3'b110 grants 010 (rr_ptr reset to 0).
